traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Consumes the single-cycle 1 Hz enable from the clock divider and steps a two-road intersection
//  through its light phases. Each phase has a tick-counted duration. Main road rests on green until
//  a side-road request arrives. Sits between the divider and the lamp driver outputs.
// PARAMETERS
//  T_MAIN_GREEN  10  min main-green ticks (1..2^CNT_W-1)
//  T_YELLOW       3  yellow ticks, both roads
//  T_ALL_RED      1  all-red clearance ticks between greens
//  T_SIDE_GREEN   6  side-green ticks
//  CNT_W          6  phase timer width
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous, active-low reset
//  oneHz_enable  in   1      1-cycle tick from divider; all timing advances only on it
//  side_req      in   1      side-road vehicle sensor, level or pulse, any cycle
//  main_light    out  3      {R,Y,G} main road, one-hot
//  side_light    out  3      {R,Y,G} side road, one-hot
//  phase         out  3      state code (encoding below)
//  remaining     out  CNT_W  ticks left in current phase
// BEHAVIOUR
//  - All logic on posedge clk; rst==0 sampled at clk edge overrides everything, including a tick.
//  - Reset values: phase=MAIN_G, remaining=T_MAIN_GREEN, main_light=001, side_light=100, req_pend=0.
//  - States/codes: MAIN_G=0, MAIN_Y=1, RED_1=2, SIDE_G=3, SIDE_Y=4, RED_2=5; codes 6,7 -> MAIN_G reload.
//  - Lights: MAIN_G main=001 side=100; MAIN_Y main=010 side=100; RED_1/RED_2 both 100;
//    SIDE_G main=100 side=001; SIDE_Y main=100 side=010. Never both non-red.
//  - Lights are registered and change in the same edge as phase (no extra latency).
//  - Timer: on entry, remaining loads the duration. On a tick with remaining>1, remaining decrements.
//    On a tick with remaining==1, the phase ends. Each phase therefore lasts exactly N ticks.
//  - No tick: no change, except req_pend capture.
//  - Order: MAIN_G->MAIN_Y->RED_1->SIDE_G->SIDE_Y->RED_2->MAIN_G.
//  - MAIN_G exit: needs an expiring tick and (req_pend | side_req). Otherwise remaining holds at 1.
//    Once the request arrives, exit happens on the next tick.
//  - req_pend: set on any cycle with side_req=1. Cleared on the cycle of entry to SIDE_G.
//    A request during SIDE_G..RED_2 re-sets it and gives another side cycle after the min main green.
//  - Request and expiring tick in the same cycle: transition happens that cycle.
//  - Duration parameter of 0 is treated as 1.
//  - remaining never wraps below 1.
// CONFIGURATION
//  PED_WALK_EN defined:
//   - Adds input ped_req (1) and output walk (1, reset 0).
//   - ped_req is latched like side_req, into ped_pend, and counts as a MAIN_G exit request.
//   - walk=1 throughout SIDE_G (pedestrians cross main road), else 0; it is registered with phase.
//   - ped_pend clears on SIDE_G entry.
//  PED_WALK_EN undefined: the ped_req and walk ports and the ped_pend logic are absent; all else identical.
// TESTING
//  1 Reset: rst=0 for 2 clks, with ticks present -> phase=0, remaining=10, main=001, side=100.
//  2 No request, 30 ticks -> stays MAIN_G; remaining counts 10..1 then holds 1.
//  3 side_req pulsed 1 clk at tick 4 -> MAIN_Y after tick 10, 3 ticks. Then RED_1 1 tick,
//    SIDE_G 6 ticks, SIDE_Y 3 ticks, RED_2 1 tick, then MAIN_G with remaining=10.
//  4 Held in MAIN_G at remaining=1, side_req asserted -> MAIN_Y on next tick, remaining=3.
//  5 rst=0 mid SIDE_G at remaining=4 -> next clk phase=0, lights 001/100, req_pend=0.
//  6 PED_WALK_EN: ped_req at tick 2 -> walk=1 exactly during the 6 SIDE_G ticks;
//    lamps are never green on both roads, checked every cycle by assertion.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer advanced by a 1 Hz enable from the clock divider.
// Optional pedestrian walk phase: define PED_WALK_EN to add ped_req/walk.
module traffic_phase_sequencer #(
    parameter int unsigned T_MAIN_GREEN = 10,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned T_SIDE_GREEN = 6,
    parameter int unsigned CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oneHz_enable,
    input  logic             side_req,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
`ifdef PED_WALK_EN
    ,
    input  logic             ped_req,
    output logic             walk
`endif
);

    localparam logic [2:0] MAIN_G = 3'd0;
    localparam logic [2:0] MAIN_Y = 3'd1;
    localparam logic [2:0] RED_1  = 3'd2;
    localparam logic [2:0] SIDE_G = 3'd3;
    localparam logic [2:0] SIDE_Y = 3'd4;
    localparam logic [2:0] RED_2  = 3'd5;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // A zero duration would stall the timer, so it is promoted to one tick.
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] D_MAIN_G = (T_MAIN_GREEN == 0) ? ONE : CNT_W'(T_MAIN_GREEN);
    localparam logic [CNT_W-1:0] D_YELLOW = (T_YELLOW == 0)     ? ONE : CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] D_RED    = (T_ALL_RED == 0)    ? ONE : CNT_W'(T_ALL_RED);
    localparam logic [CNT_W-1:0] D_SIDE_G = (T_SIDE_GREEN == 0) ? ONE : CNT_W'(T_SIDE_GREEN);

    function automatic logic [2:0] succ_of(input logic [2:0] p);
        succ_of = (p == RED_2) ? MAIN_G : p + 3'd1;
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] p);
        case (p)
            MAIN_Y, SIDE_Y: dur_of = D_YELLOW;
            RED_1, RED_2:   dur_of = D_RED;
            SIDE_G:         dur_of = D_SIDE_G;
            default:        dur_of = D_MAIN_G;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(input logic [2:0] p);
        case (p)
            MAIN_G:  main_lamp = LAMP_G;
            MAIN_Y:  main_lamp = LAMP_Y;
            default: main_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input logic [2:0] p);
        case (p)
            SIDE_G:  side_lamp = LAMP_G;
            SIDE_Y:  side_lamp = LAMP_Y;
            default: side_lamp = LAMP_R;
        endcase
    endfunction

    logic             req_pend, nxt_req_pend;
    logic [2:0]       nxt_phase;
    logic [CNT_W-1:0] nxt_rem;
    logic             exit_req;
    logic             enter_side;

`ifdef PED_WALK_EN
    logic ped_pend, nxt_ped_pend;
    assign exit_req = req_pend | side_req | ped_pend | ped_req;
`else
    assign exit_req = req_pend | side_req;
`endif

    always_comb begin
        nxt_phase = phase;
        nxt_rem   = remaining;
        case (phase)
            MAIN_G, MAIN_Y, RED_1, SIDE_G, SIDE_Y, RED_2: begin
                if (oneHz_enable) begin
                    if (remaining > ONE) begin
                        nxt_rem = remaining - ONE;
                    end else if (phase != MAIN_G || exit_req) begin
                        nxt_phase = succ_of(phase);
                        nxt_rem   = dur_of(succ_of(phase));
                    end else begin
                        nxt_rem = ONE;  // main green rests here until a request arrives
                    end
                end
            end
            default: begin
                nxt_phase = MAIN_G;
                nxt_rem   = D_MAIN_G;
            end
        endcase
    end

    assign enter_side   = (nxt_phase == SIDE_G) && (phase != SIDE_G);
    assign nxt_req_pend = enter_side ? 1'b0 : (req_pend | side_req);
`ifdef PED_WALK_EN
    assign nxt_ped_pend = enter_side ? 1'b0 : (ped_pend | ped_req);
`endif

    // Lamps are decoded from the next phase so they switch on the same edge as phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= MAIN_G;
            remaining  <= D_MAIN_G;
            main_light <= LAMP_G;
            side_light <= LAMP_R;
            req_pend   <= 1'b0;
`ifdef PED_WALK_EN
            ped_pend   <= 1'b0;
            walk       <= 1'b0;
`endif
        end else begin
            phase      <= nxt_phase;
            remaining  <= nxt_rem;
            main_light <= main_lamp(nxt_phase);
            side_light <= side_lamp(nxt_phase);
            req_pend   <= nxt_req_pend;
`ifdef PED_WALK_EN
            ped_pend   <= nxt_ped_pend;
            walk       <= (nxt_phase == SIDE_G);
`endif
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: a phase-table model pushes the expected
// post-edge state each cycle; it is popped and compared after the edge.
module tb_traffic_phase_sequencer;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             oneHz_enable = 1'b0;
    logic             side_req = 1'b0;
    logic [2:0]       main_light, side_light, phase;
    logic [CNT_W-1:0] remaining;
    logic             ped_req = 1'b0;
    logic             walk;

    traffic_phase_sequencer #(
        .T_MAIN_GREEN(10), .T_YELLOW(3), .T_ALL_RED(1), .T_SIDE_GREEN(6), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .oneHz_enable(oneHz_enable),
        .side_req(side_req),
        .main_light(main_light),
        .side_light(side_light),
        .phase(phase),
        .remaining(remaining)
`ifdef PED_WALK_EN
        ,
        .ped_req(ped_req),
        .walk(walk)
`endif
    );

`ifndef PED_WALK_EN
    assign walk = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        int         rem;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wk;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: durations and lamp patterns indexed by phase code.
    int         dur_tbl[6]  = '{10, 3, 1, 6, 3, 1};
    logic [2:0] main_tbl[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tbl[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int m_phase = 0, m_rem = 10;
    bit m_pend = 0, m_ped = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit t, input bit s, input bit p);
        exp_t e;
        bit   any_req, np, npd;
        if (!r) begin
            m_phase = 0; m_rem = 10; m_pend = 0; m_ped = 0;
        end else begin
            any_req = m_pend | s;
`ifdef PED_WALK_EN
            any_req = any_req | m_ped | p;
`endif
            np  = m_pend | s;
            npd = m_ped | p;
            if (t) begin
                if (m_rem > 1) m_rem--;
                else if (m_phase != 0 || any_req) begin
                    m_phase = (m_phase + 1) % 6;
                    m_rem   = dur_tbl[m_phase];
                    if (m_phase == 3) begin np = 0; npd = 0; end
                end
            end
            m_pend = np;
            m_ped  = npd;
        end
        e.ph  = 3'(m_phase);
        e.rem = m_rem;
        e.ml  = main_tbl[m_phase];
        e.sl  = side_tbl[m_phase];
`ifdef PED_WALK_EN
        e.wk  = (m_phase == 3);
`else
        e.wk  = 1'b0;
`endif
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit p);
        exp_t e;
        rst = r; oneHz_enable = t; side_req = s; ped_req = p;
        model_step(r, t, s, p);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = q.pop_front();
            chk("phase", 32'(phase), 32'(e.ph));
            chk("remaining", 32'(remaining), 32'(e.rem));
            chk("lamps", {26'd0, main_light, side_light}, {26'd0, e.ml, e.sl});
            chk("walk", 32'(walk), 32'(e.wk));
        end
    endtask

    // One tick period: request (if any) on the first idle cycle, optional request on the tick cycle.
    task automatic one_tick(input bit s, input bit p, input bit s_on_tick);
        cyc(1, 0, s, p);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, s_on_tick, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_tick(0, 0, 0);
    endtask

    // Lamps must never be non-red on both roads.
    always @(negedge clk)
        if (rst) chk("exclusive", 32'(main_light != 3'b100 && side_light != 3'b100), 0);

    int walk_ticks;

    initial begin
        #1;
        // Reset held over two clocks with ticks present
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_rem", 32'(remaining), 10);
        chk("rst_lamps", {26'd0, main_light, side_light}, {26'd0, 3'b001, 3'b100});

        // No request: main green holds at remaining=1
        ticks(30);
        chk("hold_phase", 32'(phase), 0);
        chk("hold_rem", 32'(remaining), 1);

        // Full cycle, side_req pulsed after tick 4
        cyc(0, 0, 0, 0);
        ticks(4);
        one_tick(1, 0, 0);
        ticks(4);
        chk("pre_exit", 32'(phase), 0);
        ticks(1);
        chk("main_y", 32'(phase), 1);
        chk("main_y_rem", 32'(remaining), 3);
        ticks(14);
        chk("back_main", 32'(phase), 0);
        chk("back_rem", 32'(remaining), 10);

        // Request on the expiring tick itself
        ticks(9);
        one_tick(0, 0, 1);
        chk("same_cyc_ph", 32'(phase), 1);
        chk("same_cyc_rem", 32'(remaining), 3);

        // Reach SIDE_G with remaining=4 and a pending request, then reset
        ticks(5);
        one_tick(1, 0, 0);
        chk("side_g", 32'(phase), 3);
        chk("side_g_rem", 32'(remaining), 4);
        cyc(0, 1, 0, 0);
        chk("mid_rst_ph", 32'(phase), 0);
        chk("mid_rst_lamps", {26'd0, main_light, side_light}, {26'd0, 3'b001, 3'b100});
        ticks(15);
        chk("pend_cleared", 32'(phase), 0);

`ifdef PED_WALK_EN
        // Pedestrian request alone drives a side cycle with walk during SIDE_G
        cyc(0, 0, 0, 0);
        one_tick(0, 0, 0);
        one_tick(0, 1, 0);
        walk_ticks = 0;
        for (int i = 0; i < 24; i++) begin
            one_tick(0, 0, 0);
            if (walk) walk_ticks++;
        end
        chk("walk_ticks", 32'(walk_ticks), 6);
        chk("ped_done", 32'(phase), 0);
`else
        walk_ticks = 0;
`endif

        chk("sb_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
